// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the nibble-serial ALU controller.
// FSM state encoding, ctl word bit positions and the standard ctl words.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ctl = {ex, nx, ey, ny, f, no}
    localparam int CTL_EX = 5;
    localparam int CTL_NX = 4;
    localparam int CTL_EY = 3;
    localparam int CTL_NY = 2;
    localparam int CTL_F  = 1;
    localparam int CTL_NO = 0;

    localparam logic [5:0] CTL_ADD  = 6'h2A;
    localparam logic [5:0] CTL_AND  = 6'h28;
    localparam logic [5:0] CTL_SUB  = 6'h3B;
    localparam logic [5:0] CTL_ZERO = 6'h02;

endpackage

// File: rtl/alu_nibble_seq_alu4.sv
// alu_nibble_seq_alu4: the 4-bit ALU4 slice. ex/ey enable (else zero) an operand,
// nx/ny invert it, f selects add (with carry) or AND, no inverts the output.
// The carry out is always the adder carry so it can be chained between nibbles.
module alu_nibble_seq_alu4
    import alu_seq_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic [5:0] ctl_i,
    input  logic       cin_i,
    output logic [3:0] out_o,
    output logic       cout_o
);

    logic [3:0] xa;
    logic [3:0] yb;
    logic [4:0] sum;
    logic [3:0] pre;

    // Operand conditioning, add/AND select and output inversion for one nibble
    always_comb begin
        xa = ctl_i[CTL_EX] ? x_i : 4'h0;
        if (ctl_i[CTL_NX]) xa = ~xa;
        yb = ctl_i[CTL_EY] ? y_i : 4'h0;
        if (ctl_i[CTL_NY]) yb = ~yb;
        sum    = {1'b0, xa} + {1'b0, yb} + {4'b0000, cin_i};
        pre    = ctl_i[CTL_F] ? sum[3:0] : (xa & yb);
        out_o  = ctl_i[CTL_NO] ? ~pre : pre;
        cout_o = sum[4];
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a WIDTH-bit ALU operation through one ALU4 slice,
// one nibble per clock, LSB nibble first, then pulses done with result/flags.
// Optional feature macro: ALU_NIBBLE_SEQ_CARRY_EN (carry_in and carry_flag live).
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctl,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             z_flag,
    output logic             lt_flag,
    output logic             carry_flag
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    logic [5:0]        ctl_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic              acc_q;
    logic              busy_q;
    logic              done_q;
    logic              z_q;
    logic              lt_q;
    logic              cf_q;

    logic              accept;
    logic              carry_init;
    logic              cf_d;
    logic [3:0]        x_nib [NIBBLES];
    logic [3:0]        y_nib [NIBBLES];
    logic [NIBBLES-1:0] nib_we;
    logic [3:0]        slice_out;
    logic              slice_cout;

    assign accept = (state_q == ST_IDLE) && start;

`ifdef ALU_NIBBLE_SEQ_CARRY_EN
    assign carry_init = carry_in;
    assign cf_d       = slice_cout & ctl_q[CTL_F];
`else
    // carry_in has no function in this build; the chain still starts from 0
    logic unused_carry_in;
    assign unused_carry_in = carry_in;
    assign carry_init      = 1'b0;
    assign cf_d            = 1'b0;
`endif

    // Per-nibble operand taps, write-enable decode and result storage
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        logic [3:0] nib_q;

        assign x_nib[gi]  = x_q[4*gi +: 4];
        assign y_nib[gi]  = y_q[4*gi +: 4];
        assign nib_we[gi] = (state_q == ST_RUN) && (idx_q == IDXW'(gi));

        // Result nibble: cleared on accept, written in its own RUN cycle
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)        nib_q <= 4'h0;
            else if (accept)     nib_q <= 4'h0;
            else if (nib_we[gi]) nib_q <= slice_out;
        end

        assign result[4*gi +: 4] = nib_q;
    end

    alu_nibble_seq_alu4 u_alu4 (
        .x_i    (x_nib[idx_q]),
        .y_i    (y_nib[idx_q]),
        .ctl_i  (ctl_q),
        .cin_i  (carry_q),
        .out_o  (slice_out),
        .cout_o (slice_cout)
    );

    // Sequencer: latch on accept, chain carry/zero-accumulate per nibble, flag on DONE entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ctl_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            lt_q    <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        x_q     <= x;
                        y_q     <= y;
                        ctl_q   <= ctl;
                        carry_q <= carry_init;
                        idx_q   <= '0;
                        acc_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_cout;
                    acc_q   <= acc_q | (|slice_out);
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        // Zero is judged on the final (post-inversion) output
                        z_q     <= ~(acc_q | (|slice_out));
                        lt_q    <= slice_out[3];
                        cf_q    <= cf_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign z_flag     = z_q;
    assign lt_flag    = lt_q;
    assign carry_flag = cf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: table vectors, hand-written multi-cycle sequences and
// random operations checked against a full-width arithmetic reference model.
module tb_alu_nibble_seq;

`ifdef ALU_NIBBLE_SEQ_CARRY_EN
    localparam bit CF_ON = 1'b1;
`else
    localparam bit CF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [5:0]  ctl = '0;
    logic        carry_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        z_flag;
    logic        lt_flag;
    logic        carry_flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .x          (x),
        .y          (y),
        .ctl        (ctl),
        .carry_in   (carry_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .z_flag     (z_flag),
        .lt_flag    (lt_flag),
        .carry_flag (carry_flag)
    );

    typedef struct {
        logic [15:0] xv;
        logic [15:0] yv;
        logic [5:0]  cv;
        bit          ci;
        logic [15:0] exp_r;
        bit          exp_z;
        bit          exp_lt;
        bit          exp_cf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full-width Nand2Tetris-style ALU computed directly on whole operands
    function automatic void model(input logic [15:0] xv, input logic [15:0] yv,
                                  input logic [5:0] c, input bit ci,
                                  output logic [15:0] r, output bit z,
                                  output bit lt, output bit cf);
        logic [15:0] a, b, o;
        logic [16:0] s;
        a = c[5] ? xv : 16'h0;
        if (c[4]) a = ~a;
        b = c[3] ? yv : 16'h0;
        if (c[2]) b = ~b;
        s = {1'b0, a} + {1'b0, b} + ((CF_ON && ci) ? 17'd1 : 17'd0);
        o = c[1] ? s[15:0] : (a & b);
        if (c[0]) o = ~o;
        r  = o;
        z  = (o == 16'h0);
        lt = o[15];
        cf = CF_ON && c[1] && s[16];
    endfunction

    // One operation: accept, scramble inputs, watch busy/done for a bounded time
    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv,
                          input logic [5:0] cv, input bit ci,
                          output logic [15:0] r, output bit z, output bit lt,
                          output bit cf, output int lat, output int busy_n,
                          output int done_n);
        @(negedge clk);
        x = xv; y = yv; ctl = cv; carry_in = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x = 16'($urandom); y = 16'($urandom); ctl = 6'($urandom); carry_in = 1'($urandom);
        lat = 0; busy_n = 0; done_n = 0;
        r = 16'hxxxx; z = 1'b0; lt = 1'b0; cf = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) begin
                    lat = k; r = result; z = z_flag; lt = lt_flag; cf = carry_flag;
                end
            end
            if (!busy) break;
        end
        $display("[TB] op ctl=%02h x=%04h y=%04h cin=%0d -> result=%04h z=%0d lt=%0d cf=%0d lat=%0d",
                 cv, xv, yv, ci, r, z, lt, cf, lat);
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] r, er;
        bit          z, lt, cf, ez, elt, ecf;
        int          lat, bn, dn, cnt_b, cnt_d;

        vecs[0] = '{16'h0FFF, 16'h0001, 6'h2A, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 6'h2A, 1'b0, 16'h0000, 1'b1, 1'b0, CF_ON};
        vecs[2] = '{16'hF0F0, 16'hFF00, 6'h28, 1'b0, 16'hF000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 6'h3B, 1'b0, 16'hFFFE, 1'b0, 1'b1, CF_ON};
        vecs[4] = '{16'h1234, 16'hABCD, 6'h02, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h0001, 16'h0002, 6'h2A, 1'b1, CF_ON ? 16'h0004 : 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0001, 6'h2B, 1'b0, 16'hFFFF, 1'b0, 1'b1, CF_ON};

        // Reset values while reset_n is held low
        x = 16'($urandom); y = 16'($urandom); start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, z_flag, lt_flag, carry_flag}, 32'd0);
        start = 1'b0;
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].xv, vecs[i].yv, vecs[i].cv, vecs[i].ci, r, z, lt, cf, lat, bn, dn);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_r));
            check($sformatf("vec%0d_z", i), 32'(z), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d_lt", i), 32'(lt), 32'(vecs[i].exp_lt));
            check($sformatf("vec%0d_cf", i), 32'(cf), 32'(vecs[i].exp_cf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'd5);
            check($sformatf("vec%0d_done_pulses", i), 32'(dn), 32'd1);
            check($sformatf("vec%0d_hold", i), 32'(result), 32'(vecs[i].exp_r));
        end

        // ZERO op with a second start pulsed during RUN: must be ignored
        @(negedge clk);
        x = 16'h5555; y = 16'h3333; ctl = 6'h02; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        cnt_b = 0; cnt_d = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin x = 16'h0001; y = 16'h0001; ctl = 6'h2A; end
            if (busy) cnt_b++;
            if (done) begin
                cnt_d++;
                check("ignore_result", 32'(result), 32'h0000);
                check("ignore_z", 32'(z_flag), 32'd1);
            end
        end
        $display("[TB] op ZERO with start during RUN: busy_cycles=%0d done_pulses=%0d", cnt_b, cnt_d);
        check("ignore_busy_cycles", 32'(cnt_b), 32'd5);
        check("ignore_done_pulses", 32'(cnt_d), 32'd1);

        // start held high: re-accept in the first IDLE cycle, period NIBBLES+2
        @(negedge clk);
        x = 16'h0010; y = 16'h0020; ctl = 6'h2A; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        cnt_b = 0; cnt_d = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (!busy) cnt_b++;
            if (done) begin
                cnt_d++;
                check($sformatf("stream_done_at_%0d", k), 32'(k % 6), 32'd5);
                check("stream_result", 32'(result), 32'h0030);
            end
        end
        start = 1'b0;
        $display("[TB] op streamed ADD: idle_cycles=%0d done_pulses=%0d", cnt_b, cnt_d);
        check("stream_idle_cycles", 32'(cnt_b), 32'd2);
        check("stream_done_pulses", 32'(cnt_d), 32'd2);
        cnt_b = 0;
        while (busy && cnt_b < 20) begin @(negedge clk); cnt_b++; end
        check("stream_drain", 32'(busy), 32'd0);

        // Reset mid-operation: abort immediately, no done pulse
        @(negedge clk);
        x = 16'h1111; y = 16'h1111; ctl = 6'h2A; start = 1'b1;
        @(posedge clk);
        cnt_d = 0;
        @(negedge clk); start = 1'b0; if (done) cnt_d++;
        @(negedge clk); if (done) cnt_d++;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) cnt_d++;
        end
        $display("[TB] op ADD aborted by reset: stray_activity=%0d", cnt_d);
        check("abort_no_done", 32'(cnt_d), 32'd0);
        run_op(16'h0001, 16'h0002, 6'h2A, 1'b0, r, z, lt, cf, lat, bn, dn);
        check("after_abort_result", 32'(r), 32'h0003);
        check("after_abort_latency", 32'(lat), 32'd5);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] xv, yv;
            logic [5:0]  cv;
            bit          ci;
            xv = 16'($urandom); yv = 16'($urandom); cv = 6'($urandom); ci = 1'($urandom);
            if (i % 4 == 0) yv = 16'h0000;
            model(xv, yv, cv, ci, er, ez, elt, ecf);
            run_op(xv, yv, cv, ci, r, z, lt, cf, lat, bn, dn);
            check($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
            check($sformatf("rnd%0d_flags", i), {29'd0, z, lt, cf}, {29'd0, ez, elt, ecf});
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
